// File: rtl/parallel_lfsr_gen.sv
// Block-parallel Fibonacci LFSR: NUM_OUTPUTS consecutive steps per accepted block, valid/ready out.
// Define PLFSR_BLOCK_CNT_EN to enable the blk_cnt block counter and the cycle_done detector.
module parallel_lfsr_gen #(
  parameter int unsigned       WIDTH       = 8,
  parameter int unsigned       NUM_OUTPUTS = 8,
  parameter logic [WIDTH-1:0]  TAPS        = 8'hC0,
  parameter logic [WIDTH-1:0]  SEED        = WIDTH'(1),
  parameter int unsigned       CNT_W       = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         load,
  input  logic [WIDTH-1:0]             seed_in,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [NUM_OUTPUTS*WIDTH-1:0] random,
  output logic [WIDTH-1:0]             lfsr,
  output logic                         cycle_done,
  output logic [CNT_W-1:0]             blk_cnt
);

  if (WIDTH < 2 || WIDTH > 32) begin : gen_bad_width
    $error("parallel_lfsr_gen: WIDTH must be in 2..32");
  end
  if (NUM_OUTPUTS < 1) begin : gen_bad_num
    $error("parallel_lfsr_gen: NUM_OUTPUTS must be at least 1");
  end
  if (TAPS[WIDTH-1] == 1'b0) begin : gen_bad_taps
    $error("parallel_lfsr_gen: TAPS must have its MSB set");
  end
  if (SEED == '0) begin : gen_bad_seed
    $error("parallel_lfsr_gen: SEED must be non-zero");
  end

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  logic [WIDTH-1:0]             lfsr_q, lfsr_d;
  logic [NUM_OUTPUTS*WIDTH-1:0] random_q, random_d;
  logic                         valid_q, valid_d;
  logic [NUM_OUTPUTS*WIDTH-1:0] blk_next;
  logic [WIDTH-1:0]             step_s;
  logic [WIDTH-1:0]             load_seed;
  logic                         advance;

  // An all-zero seed would lock the register up, so it falls back to SEED.
  assign load_seed = (seed_in == '0) ? SEED : seed_in;
  assign advance   = en && !load && (!valid_q || out_ready);

  // Unrolled chain of NUM_OUTPUTS single steps, all evaluated in one cycle.
  always_comb begin
    blk_next = '0;
    step_s   = lfsr_q;
    for (int k = 0; k < NUM_OUTPUTS; k++) begin
      step_s                     = lfsr_step(step_s);
      blk_next[k*WIDTH +: WIDTH] = step_s;
    end
  end

  always_comb begin
    lfsr_d   = lfsr_q;
    random_d = random_q;
    valid_d  = valid_q;
    if (load) begin
      lfsr_d  = load_seed;
      valid_d = 1'b0;
    end else if (advance) begin
      lfsr_d   = blk_next[(NUM_OUTPUTS-1)*WIDTH +: WIDTH];
      random_d = blk_next;
      valid_d  = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      lfsr_q   <= SEED;
      random_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      random_q <= random_d;
      valid_q  <= valid_d;
    end
  end

  assign lfsr      = lfsr_q;
  assign random    = random_q;
  assign out_valid = valid_q;

`ifdef PLFSR_BLOCK_CNT_EN
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  always_comb begin
    seed_d = seed_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (load) begin
      seed_d = load_seed;
      cnt_d  = '0;
    end else if (advance) begin
      cnt_d  = cnt_q + CNT_W'(1);
      done_d = (lfsr_d == seed_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      seed_q <= SEED;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      seed_q <= seed_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign blk_cnt    = cnt_q;
  assign cycle_done = done_q;
`else
  assign blk_cnt    = '0;
  assign cycle_done = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_lfsr_gen.sv
// Bench for parallel_lfsr_gen: directed vector table, randomized run against a reference model,
// and a full-period run on a 4-bit instance.
module tb_parallel_lfsr_gen;

`ifdef PLFSR_BLOCK_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        rst_n, en, load, rdy;
  logic [7:0]  seed;
  logic        valid, done;
  logic [63:0] rnd;
  logic [7:0]  lfsr;
  logic [15:0] cnt;

  parallel_lfsr_gen u_dut (
    .clk        (clk),
    .reset      (rst_n),
    .en         (en),
    .load       (load),
    .seed_in    (seed),
    .out_ready  (rdy),
    .out_valid  (valid),
    .random     (rnd),
    .lfsr       (lfsr),
    .cycle_done (done),
    .blk_cnt    (cnt)
  );

  // 4-bit maximal-length instance
  logic        rst4_n, en4, load4, rdy4;
  logic [3:0]  seed4;
  logic        valid4, done4;
  logic [3:0]  rnd4, lfsr4, cnt4;

  parallel_lfsr_gen #(
    .WIDTH       (4),
    .NUM_OUTPUTS (1),
    .TAPS        (4'hC),
    .SEED        (4'h1),
    .CNT_W       (4)
  ) u_dut4 (
    .clk        (clk),
    .reset      (rst4_n),
    .en         (en4),
    .load       (load4),
    .seed_in    (seed4),
    .out_ready  (rdy4),
    .out_valid  (valid4),
    .random     (rnd4),
    .lfsr       (lfsr4),
    .cycle_done (done4),
    .blk_cnt    (cnt4)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: shift left, feed back parity of tapped bits.
  function automatic int unsigned m_step(input int unsigned s, input int unsigned w,
                                         input int unsigned taps);
    int unsigned fb;
    fb = $countones(s & taps) & 1;
    return ((s << 1) | fb) & ((1 << w) - 1);
  endfunction

  typedef struct {
    logic        rst_n, en, load, rdy;
    logic [7:0]  seed;
    logic        exp_valid;
    logic [7:0]  exp_lfsr;
    logic [63:0] exp_rnd;
    int unsigned exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic e, input logic l, input logic rd,
                         input logic [7:0] sd, input logic v, input logic [7:0] lf,
                         input logic [63:0] rn, input int unsigned c);
    vec_t x;
    x.rst_n = r; x.en = e; x.load = l; x.rdy = rd; x.seed = sd;
    x.exp_valid = v; x.exp_lfsr = lf; x.exp_rnd = rn; x.exp_cnt = c;
    vecs.push_back(x);
  endtask

  // Reference model state for the default instance
  int unsigned m_lfsr, m_seed, m_cnt;
  bit          m_valid, m_done;
  int unsigned m_rand[8];

  task automatic model_edge(input bit r, input bit e, input bit l, input bit rd,
                            input int unsigned sd);
    int unsigned s;
    bit adv;
    if (!r) begin
      m_lfsr = 1; m_seed = 1; m_valid = 0; m_done = 0; m_cnt = 0;
      foreach (m_rand[k]) m_rand[k] = 0;
    end else if (l) begin
      s = (sd == 0) ? 1 : sd;
      m_lfsr = s; m_seed = s; m_valid = 0; m_done = 0; m_cnt = 0;
    end else begin
      adv    = e && (!m_valid || rd);
      m_done = 0;
      if (adv) begin
        s = m_lfsr;
        for (int k = 0; k < 8; k++) begin
          s = m_step(s, 8, 'hC0);
          m_rand[k] = s;
        end
        m_lfsr  = s;
        m_valid = 1;
        m_cnt   = (m_cnt + 1) % 65536;
        m_done  = (m_lfsr == m_seed);
      end else if (m_valid && rd) begin
        m_valid = 0;
      end
    end
  endtask

  localparam logic [63:0] B1 = 64'h0381_4020_1008_0402;
  localparam logic [63:0] B2 = 64'h0582_C160_3018_0C06;

  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; rdy = 1'b0; seed = 8'h00;
    rst4_n = 1'b0; en4 = 1'b0; load4 = 1'b0; rdy4 = 1'b0; seed4 = 4'h0;

    //      rst   en    load  rdy   seed   valid lfsr   random cnt
    add_vec(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 64'h0, 0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h03, B1,    1);
    for (int i = 0; i < 5; i++)
      add_vec(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 8'h03, B1,  1);
    add_vec(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h05, B2,    2);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h05, B2,    2);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h05, B2,    2);
    add_vec(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 8'h01, B2,    0);
    add_vec(1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b0, 8'h5A, B2,    0);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, B2,    0);
    add_vec(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 8'h03, B1,    1);
    add_vec(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 64'h0, 0);
    add_vec(1'b0, 1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 8'h01, 64'h0, 0);
    add_vec(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 64'h0, 0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; en = vecs[i].en; load = vecs[i].load;
      rdy = vecs[i].rdy; seed = vecs[i].seed;
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), 64'(valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d lfsr", i), 64'(lfsr), 64'(vecs[i].exp_lfsr));
      chk($sformatf("vec%0d random", i), rnd, vecs[i].exp_rnd);
      chk($sformatf("vec%0d blk_cnt", i), 64'(cnt), CntEn ? 64'(vecs[i].exp_cnt) : 64'h0);
      chk($sformatf("vec%0d cycle_done", i), 64'(done), 64'h0);
    end

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      rst_n = (i == 0) ? 1'b0 : ($urandom_range(0, 49) != 0);
      en    = ($urandom_range(0, 3) != 0);
      load  = ($urandom_range(0, 19) == 0);
      rdy   = ($urandom_range(0, 2) != 0);
      seed  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      @(posedge clk);
      model_edge(rst_n, en, load, rdy, seed);
      #1;
      chk($sformatf("rnd%0d out_valid", i), 64'(valid), 64'(m_valid));
      chk($sformatf("rnd%0d lfsr", i), 64'(lfsr), 64'(m_lfsr));
      for (int k = 0; k < 8; k++)
        chk($sformatf("rnd%0d random[%0d]", i, k), 64'(rnd[k*8 +: 8]), 64'(m_rand[k]));
      chk($sformatf("rnd%0d blk_cnt", i), 64'(cnt), CntEn ? 64'(m_cnt) : 64'h0);
      chk($sformatf("rnd%0d cycle_done", i), 64'(done), CntEn ? 64'(m_done) : 64'h0);
    end

    // 4-bit instance: full period of 15, counter wrap at 16
    begin
      int unsigned s4;
      s4 = 1;
      rst4_n = 1'b0; en4 = 1'b1; rdy4 = 1'b1;
      @(posedge clk); #1;
      chk("w4 reset lfsr", 64'(lfsr4), 64'h1);
      chk("w4 reset valid", 64'(valid4), 64'h0);
      rst4_n = 1'b1;
      for (int n = 1; n <= 32; n++) begin
        @(posedge clk); #1;
        s4 = m_step(s4, 4, 'hC);
        chk($sformatf("w4 adv%0d lfsr", n), 64'(lfsr4), 64'(s4));
        chk($sformatf("w4 adv%0d random", n), 64'(rnd4), 64'(s4));
        chk($sformatf("w4 adv%0d out_valid", n), 64'(valid4), 64'h1);
        chk($sformatf("w4 adv%0d cycle_done", n), 64'(done4),
            (CntEn && (n % 15 == 0)) ? 64'h1 : 64'h0);
        chk($sformatf("w4 adv%0d blk_cnt", n), 64'(cnt4), CntEn ? 64'(n % 16) : 64'h0);
      end
      en4 = 1'b0;
      @(posedge clk); #1;
      chk("w4 idle cycle_done", 64'(done4), 64'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
